// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control unit for the multi-cycle CPU datapath.
//
// Latches each instruction into an instruction register during FETCH, decodes it
// into the datapath control bus and sequences it through
// FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) -> FETCH, handshaking with data memory via mem_ready.
//
// Optional feature macro: CTRL_HALT_EN. When defined, opcode 5'h1F parks the FSM in HALT
// (no en_exe_pulse, no retire) until reset. When undefined, 5'h1F is an ordinary NOP.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   instruction    in   [31:0] instruction memory read data
//   flag           in   [1:0]  ALU flags, sampled into status during EXECUTE
//   mem_ready      in   data memory completed the current access (only looked at in MEM)
//   opcode         out  [4:0]  ir[31:27]
//   Rd, Rs, Rt     out  [3:0]  ir[26:23], ir[22:19], ir[18:15]
//   imm_ext        out  [31:0] sign-extended ir[IMM_W-1:0]
//   in2_muxcontrol out  1 = register operand (R-type), 0 = immediate
//   wv_muxcontrol  out  1 = write back read_data (LW in WB), 0 = alu_result
//   en_exe_pulse   out  one-cycle execute strobe, advances the PC
//   regwrite       out  register file write strobe
//   mem_read       out  data memory read request
//   mem_write      out  data memory write request
//   state          out  [2:0] FSM state encoding
//   retired        out  [CNT_W-1:0] completed instruction count (wraps)
//   status         out  [1:0] flag captured during EXECUTE
module multicycle_ctrl #(
  parameter int unsigned IMM_W = 15,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [1:0]       flag,
  input  logic             mem_ready,
  output logic [4:0]       opcode,
  output logic [3:0]       Rd,
  output logic [3:0]       Rs,
  output logic [3:0]       Rt,
  output logic [31:0]      imm_ext,
  output logic             in2_muxcontrol,
  output logic             wv_muxcontrol,
  output logic             en_exe_pulse,
  output logic             regwrite,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       status
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StHalt    = 3'd5
  } state_e;

  localparam logic [4:0] OpSlt  = 5'h05;  // R-type opcodes are 5'h00..5'h05
  localparam logic [4:0] OpAddi = 5'h08;
  localparam logic [4:0] OpAndi = 5'h09;
  localparam logic [4:0] OpOri  = 5'h0A;
  localparam logic [4:0] OpLw   = 5'h10;
  localparam logic [4:0] OpSw   = 5'h11;
`ifdef CTRL_HALT_EN
  localparam logic [4:0] OpHalt = 5'h1F;
`endif

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic             in2_q, in2_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [4:0] op;
  logic       is_alu, is_lw, is_sw, halt_op, rd_nz;

  assign op     = ir_q[31:27];
  assign is_alu = (op <= OpSlt) || (op == OpAddi) || (op == OpAndi) || (op == OpOri);
  assign is_lw  = (op == OpLw);
  assign is_sw  = (op == OpSw);
  assign rd_nz  = (ir_q[26:23] != 4'd0);
`ifdef CTRL_HALT_EN
  assign halt_op = (op == OpHalt);
`else
  assign halt_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      in2_q     <= 1'b0;
      status_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      in2_q     <= in2_d;
      status_q  <= status_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    in2_d     = in2_q;
    status_d  = status_q;
    retired_d = retired_q;
    unique case (state_q)
      StFetch: begin
        ir_d    = instruction;
        // Operand select is registered alongside the IR so it reads 0 out of reset.
        in2_d   = (instruction[31:27] <= OpSlt);
        state_d = StDecode;
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        status_d = flag;
        if (halt_op) begin
          state_d = StHalt;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else if (is_alu && rd_nz) begin
          state_d = StWb;
        end else begin
          // Branch/JMP/NOP, and ALU ops targeting read-only r0, retire here.
          state_d = StFetch;
        end
      end
      StMem: begin
        if (mem_ready) state_d = is_lw ? StWb : StFetch;
      end
      StWb: state_d = StFetch;
`ifdef CTRL_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase
    if ((state_d == StFetch) &&
        ((state_q == StExecute) || (state_q == StMem) || (state_q == StWb))) begin
      retired_d = retired_q + CntOne;
    end
  end

  // All outputs derive from registered state only.
  assign opcode         = op;
  assign Rd             = ir_q[26:23];
  assign Rs             = ir_q[22:19];
  assign Rt             = ir_q[18:15];
  assign imm_ext        = {{(32-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign in2_muxcontrol = in2_q;
  assign wv_muxcontrol  = (state_q == StWb) && is_lw;
  assign en_exe_pulse   = (state_q == StExecute) && !halt_op;
  assign regwrite       = (state_q == StWb);
  assign mem_read       = (state_q == StMem) && is_lw;
  assign mem_write      = (state_q == StMem) && is_sw;
  assign state          = state_q;
  assign retired        = retired_q;
  assign status         = status_q;

endmodule
